mips_lite_exec_unit: RTL and testbench

Execute-stage datapath slice for the single-cycle MIPS-lite core. It combines three functions:
- ALU-control decode: ALUOp plus funct bits produce a 3-bit ALU operation.
- 32-bit ALU: produces a result, a zero flag and a signed-overflow flag.
- Address adders: PC+4 and the branch target.

A clocked status register holds the V and Z flags of the last ALU operation. The conditional branch/balrnv PC-source logic consumes these flags.

---
 rtl/mips_lite_exec_unit_pkg.sv | 18 +
 rtl/mips_lite_exec_unit_alu_core.sv | 53 +++++
 rtl/mips_lite_exec_unit.sv | 72 +++++++
 tb/tb_mips_lite_exec_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_lite_exec_unit_pkg.sv
// Shared constants for the MIPS-lite execute stage: ALU op codes and funct codes.
package mips_lite_exec_unit_pkg;

   // ALU operation codes driven on gout
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // R-type funct[3:0] codes recognised by the ALU-control decode
   localparam logic [3:0] FUNCT_ADD = 4'b0000;
   localparam logic [3:0] FUNCT_SUB = 4'b0010;
   localparam logic [3:0] FUNCT_AND = 4'b0100;
   localparam logic [3:0] FUNCT_OR  = 4'b0101;
   localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/mips_lite_exec_unit_alu_core.sv
// Combinational ALU datapath with zero and signed-overflow flags.
module mips_lite_alu_core
   import mips_lite_exec_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic             add_ovf;
   logic             sub_ovf;
   logic             lt;

   assign sum = a + b;
   assign dif = a - b;

   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

   // Sign of the true (WIDTH+1)-bit difference: operands of differing sign decide by a's
   // sign alone, so the result stays exact even when the WIDTH-bit subtraction overflows.
   assign lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : dif[WIDTH-1];

   // Result and overflow selection by operation code
   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result = sum;
            ovf    = add_ovf;
         end
         ALU_SUB: begin
            result = dif;
            ovf    = sub_ovf;
         end
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mips_lite_exec_unit.sv
// Execute-stage slice: ALU-control decode, ALU, PC adders and registered V/Z status flags.
module mips_lite_exec_unit
   import mips_lite_exec_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             aluop1,
   input  logic             aluop0,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] pc,
   input  logic [15:0]      imm16,
   output logic [2:0]       gout,
   output logic [WIDTH-1:0] result,
   output logic             zout,
   output logic             vout,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] br_target,
   output logic             v_flag,
   output logic             z_flag
);

   logic [WIDTH-1:0] br_offset;

   // ALU-control decode; aluop0 has priority so aluop=11 also selects subtract
   always_comb begin
      gout = ALU_ADD;
      if (aluop0) begin
         gout = ALU_SUB;
      end else if (aluop1) begin
         case (funct)
            FUNCT_ADD: gout = ALU_ADD;
            FUNCT_SUB: gout = ALU_SUB;
            FUNCT_AND: gout = ALU_AND;
            FUNCT_OR:  gout = ALU_OR;
            FUNCT_SLT: gout = ALU_SLT;
            default:   gout = ALU_ADD;
         endcase
      end
   end

   mips_lite_alu_core #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (gout),
      .a      (a),
      .b      (b),
      .result (result),
      .zero   (zout),
      .ovf    (vout)
   );

   // Word offset: sign-extended immediate shifted left by two
   assign br_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
   assign pc_plus4  = pc + WIDTH'(4);
   assign br_target = pc_plus4 + br_offset;

   // Status register: captures the flags of the current ALU operation every edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         v_flag <= vout;
         z_flag <= zout;
      end
   end

endmodule

// File: tb/tb_mips_lite_exec_unit.sv
// Self-checking bench for mips_lite_exec_unit: vector table plus flag/reset/PC sequences.
module tb_mips_lite_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        aluop1;
   logic        aluop0;
   logic [3:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] pc;
   logic [15:0] imm16;
   logic [2:0]  gout;
   logic [31:0] result;
   logic        zout;
   logic        vout;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic        v_flag;
   logic        z_flag;

   int n_checks;
   int n_fails;

   typedef struct {
      logic        op1;
      logic        op0;
      logic [3:0]  fn;
      logic [31:0] va;
      logic [31:0] vb;
      logic [2:0]  e_gout;
      logic [31:0] e_res;
      logic        e_z;
      logic        e_v;
   } vec_t;

   vec_t vecs [14];

   mips_lite_exec_unit #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .aluop1    (aluop1),
      .aluop0    (aluop0),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .pc        (pc),
      .imm16     (imm16),
      .gout      (gout),
      .result    (result),
      .zout      (zout),
      .vout      (vout),
      .pc_plus4  (pc_plus4),
      .br_target (br_target),
      .v_flag    (v_flag),
      .z_flag    (z_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic o1, input logic o0, input logic [3:0] fn,
                        input logic [31:0] va, input logic [31:0] vb);
      aluop1 = o1;
      aluop0 = o0;
      funct  = fn;
      a      = va;
      b      = vb;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;

      //          op1   op0   funct    a             b             gout    result        z     v
      vecs[0]  = '{1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 4'b0000, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'b0100, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 4'b0100, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000001, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'b0101, 32'hFFFFFFFF, 32'h00000001, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'b1010, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 4'b0000, 32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 4'b0010, 32'h00000010, 32'h00000003, 3'b110, 32'h0000000D, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 4'b0000, 32'h00000002, 32'h00000003, 3'b010, 32'h00000005, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'b0100, 32'h000000F0, 32'h0000000F, 3'b000, 32'h00000000, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'b1010, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 4'b0001, 32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1, 1'b1};

      pc    = 32'h0000000C;
      imm16 = 16'hFFFE;

      // Reset held with vout forced high: flags must stay clear on every edge
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_v_flag", {31'b0, v_flag}, 32'h0);
         check("reset_z_flag", {31'b0, z_flag}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_v_flag", {31'b0, v_flag}, 32'h1);
      check("post_reset_z_flag", {31'b0, z_flag}, 32'h0);

      // Combinational vector table
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i].op1, vecs[i].op0, vecs[i].fn, vecs[i].va, vecs[i].vb);
         #1;
         check($sformatf("vec%0d_gout", i), {29'b0, gout}, {29'b0, vecs[i].e_gout});
         check($sformatf("vec%0d_result", i), result, vecs[i].e_res);
         check($sformatf("vec%0d_zout", i), {31'b0, zout}, {31'b0, vecs[i].e_z});
         check($sformatf("vec%0d_vout", i), {31'b0, vout}, {31'b0, vecs[i].e_v});
      end

      // Branch compare registers Z, clears V
      @(negedge clk);
      drive(1'b0, 1'b1, 4'b0000, 32'h00000005, 32'h00000005);
      @(posedge clk);
      #1;
      check("beq_z_flag", {31'b0, z_flag}, 32'h1);
      check("beq_v_flag", {31'b0, v_flag}, 32'h0);

      // Add overflow registers V, clears Z
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
      @(posedge clk);
      #1;
      check("addov_v_flag", {31'b0, v_flag}, 32'h1);
      check("addov_z_flag", {31'b0, z_flag}, 32'h0);

      // Flags hold their value between edges even after inputs change
      @(negedge clk);
      drive(1'b0, 1'b1, 4'b0000, 32'h00000009, 32'h00000009);
      #1;
      check("hold_v_flag", {31'b0, v_flag}, 32'h1);
      check("hold_z_flag", {31'b0, z_flag}, 32'h0);
      @(posedge clk);
      #1;
      check("next_z_flag", {31'b0, z_flag}, 32'h1);

      // Asynchronous reset mid-cycle clears flags without an edge
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_v_flag", {31'b0, v_flag}, 32'h0);
      check("async_result_in_reset", result, 32'h80000000);
      @(negedge clk);
      rst_n = 1'b1;

      // PC adders
      pc    = 32'h0000000C;
      imm16 = 16'hFFFE;
      #1;
      check("pc4_a", pc_plus4, 32'h00000010);
      check("brt_a", br_target, 32'h00000008);
      pc    = 32'hFFFFFFFC;
      imm16 = 16'h0001;
      #1;
      check("pc4_b", pc_plus4, 32'h00000000);
      check("brt_b", br_target, 32'h00000004);
      pc    = 32'h00001000;
      imm16 = 16'h7FFF;
      #1;
      check("pc4_c", pc_plus4, 32'h00001004);
      check("brt_c", br_target, 32'h00021000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
